// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and constants for the clk_div_bank divided-clock
//               generator. Holds the per-channel state encoding, the
//               reset-time period/high defaults and the configuration
//               legality check that is used by the write decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Channel operating state. DRAIN finishes the current period after the
    // run request has been withdrawn, so no output pulse is ever truncated.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chan_state_t;

    // Smallest period that still has both a high and a low phase.
    localparam int unsigned P_MIN = 32'd2;

    // Shadow and active register values after reset: a divide-by-two clock.
    localparam int unsigned P_RST = 32'd2;
    localparam int unsigned H_RST = 32'd1;

    // A period/high pair is usable when the period has room for at least one
    // high cycle and at least one low cycle.
    function automatic logic cfg_legal(input int unsigned period,
                                       input int unsigned high);
        return (period >= P_MIN) && (high >= 32'd1) && (high <= period - 32'd1);
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divided-clock channel. Keeps a shadow copy of the
//               programmed period/high time, an active copy that is loaded
//               only when a new period starts, a period counter and a
//               three-state run controller. All outputs are registered and
//               lag the counter by one cycle.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               sh_we     - write strobe for the shadow registers
//               sh_period - new period P (clk cycles)
//               sh_high   - new high time H (clk cycles)
//               en        - run request (level)
//               clk_out   - divided clock
//               tick      - one-cycle pulse on the first cycle of a period
//               running   - channel is in RUN or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh_we,
    input  logic [CNT_W-1:0] sh_period,
    input  logic [CNT_W-1:0] sh_high,
    input  logic             en,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [CNT_W-1:0] C_P_RST = CNT_W'(P_RST);
    localparam logic [CNT_W-1:0] C_H_RST = CNT_W'(H_RST);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_p_s;
    logic [CNT_W-1:0] r_h_s;
    logic [CNT_W-1:0] r_p_a;
    logic [CNT_W-1:0] r_h_a;
    logic             w_load;
    logic             w_boundary;
    logic             w_active;

    // Last cycle of the running period.
    assign w_boundary = (r_cnt == (r_p_a - C_ONE));
    assign w_active   = (r_state != IDLE);

    // ------------------------------------------------------------------------
    // Next-state logic. w_load marks the edge on which a new period begins;
    // the active registers take the shadow value present before that edge,
    // so a shadow write landing on the same edge waits for the next period.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (en) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end

            RUN: begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (en) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (!en) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (en) begin
                        w_state_nxt = RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                    // Re-request mid-drain simply resumes; the period in
                    // flight is unaffected so no tick is skipped or added.
                    if (en) begin
                        w_state_nxt = RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Outputs decode the current counter value, giving one cycle of
            // latency and keeping every output a plain flop.
            clk_out <= w_active && (r_cnt < r_h_a);
            tick    <= w_active && (r_cnt == '0);
            running <= w_active;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow registers: written from the bus at any time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_s <= C_P_RST;
            r_h_s <= C_H_RST;
        end else if (sh_we) begin
            r_p_s <= sh_period;
            r_h_s <= sh_high;
        end
    end

    // ------------------------------------------------------------------------
    // Active registers: only change when a period starts.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_a <= C_P_RST;
            r_h_a <= C_H_RST;
        end else if (w_load) begin
            r_p_a <= r_p_s;
            r_h_a <= r_h_s;
        end
    end

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of NCH independent divided-clock / clock-enable
//               generators sharing one configuration write bus. Validates
//               each write, steers legal ones to the addressed channel's
//               shadow registers and reports the outcome one cycle later on
//               cfg_ack / cfg_err.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               cfg_we     - configuration write strobe
//               cfg_ch     - target channel of the write
//               cfg_period - period P in clk cycles
//               cfg_high   - high time H in clk cycles
//               cfg_ack    - one-cycle pulse, write accepted
//               cfg_err    - one-cycle pulse, write rejected
//               en         - per-channel run request
//               clk_out    - per-channel divided clock
//               tick       - per-channel period-start pulse
//               running    - per-channel RUN/DRAIN indicator
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]                          cfg_period,
    input  logic [CNT_W-1:0]                          cfg_high,
    output logic                                      cfg_ack,
    output logic                                      cfg_err,
    input  logic [NCH-1:0]                            en,
    output logic [NCH-1:0]                            clk_out,
    output logic [NCH-1:0]                            tick,
    output logic [NCH-1:0]                            running
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic w_ch_ok;
    logic w_legal;
    logic w_wr_ok;
    logic w_wr_bad;
    logic r_wr_ok;
    logic r_wr_bad;

    // A channel index that does not exist (possible when NCH is not a power
    // of two) is rejected along with bad period/high pairs.
    assign w_ch_ok  = (32'(cfg_ch) < 32'(NCH));
    assign w_legal  = w_ch_ok && cfg_legal(32'(cfg_period), 32'(cfg_high));
    assign w_wr_ok  = cfg_we && w_legal;
    assign w_wr_bad = cfg_we && !w_legal;

    // ------------------------------------------------------------------------
    // Write outcome pipeline: the shadow update happens on the sampling edge,
    // the acknowledge is presented one edge later. ok/bad are mutually
    // exclusive by construction, so ack and err can never coincide.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ok  <= 1'b0;
            r_wr_bad <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            r_wr_ok  <= w_wr_ok;
            r_wr_bad <= w_wr_bad;
            cfg_ack  <= r_wr_ok;
            cfg_err  <= r_wr_bad;
        end
    end

    // ------------------------------------------------------------------------
    // Channel instances.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic w_sel;

        assign w_sel = w_wr_ok && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sh_we     (w_sel),
            .sh_period (cfg_period),
            .sh_high   (cfg_high),
            .en        (en[i]),
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .running   (running[i])
        );
    end

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Self-checking bench for clk_div_bank, built with NCH=3 so an
//               out-of-range channel index can be exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_ack;
    logic             cfg_err;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   running;

    int n_cmp;
    int n_bad;

    // Expected write outcome: 1 = ack, 0 = err.
    logic exp_q[$];

    typedef struct {
        int   ch;
        int   p;
        int   h;
        logic ok;
    } cfg_vec_t;

    cfg_vec_t vecs[11];

    clk_div_bank #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .en         (en),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one write, then wait (bounded) for the outcome pulse and compare
    // it against the scoreboard entry together with its latency.
    task automatic cfg_write(input int ch, input int p, input int h, input logic ok);
        int   lat;
        logic e;
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
        exp_q.push_back(ok);
        @(negedge clk);
        cfg_we = 1'b0;
        lat = 1;
        while (!(cfg_ack || cfg_err) && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check("cfg_latency", lat, 2);
        check("cfg_ack", cfg_ack, e);
        check("cfg_err", cfg_err, !e);
        @(negedge clk);
        check("cfg_pulse_width", {cfg_ack, cfg_err}, 0);
    endtask

    task automatic wait_tick(input int ch, input int budget);
        int c;
        c = 0;
        while (!tick[ch] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("tick_seen", tick[ch], 1);
    endtask

    task automatic wait_idle(input int ch, input int budget);
        int c;
        c = 0;
        while (running[ch] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("running_drop", running[ch], 0);
        check("idle_clk_out", clk_out[ch], 0);
    endtask

    // Called on the negedge where tick[ch] is high (first cycle of a period).
    task automatic expect_periods(input int ch, input int p, input int h, input int nper);
        for (int i = 0; i < nper * p; i++) begin
            if (i > 0) @(negedge clk);
            check("wave_clk_out", clk_out[ch], (i % p) < h);
            check("wave_tick", tick[ch], (i % p) == 0);
            check("wave_running", running[ch], 1);
        end
    endtask

    initial begin
        logic e;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        en         = '0;

        vecs[0]  = '{ch: 1, p: 5,   h: 2,   ok: 1'b1};
        vecs[1]  = '{ch: 1, p: 1,   h: 1,   ok: 1'b0};
        vecs[2]  = '{ch: 1, p: 4,   h: 0,   ok: 1'b0};
        vecs[3]  = '{ch: 1, p: 6,   h: 6,   ok: 1'b0};
        vecs[4]  = '{ch: 1, p: 3,   h: 9,   ok: 1'b0};
        vecs[5]  = '{ch: 3, p: 5,   h: 2,   ok: 1'b0};
        vecs[6]  = '{ch: 2, p: 255, h: 254, ok: 1'b1};
        vecs[7]  = '{ch: 2, p: 2,   h: 1,   ok: 1'b1};
        vecs[8]  = '{ch: 0, p: 0,   h: 0,   ok: 1'b0};
        vecs[9]  = '{ch: 2, p: 6,   h: 3,   ok: 1'b1};
        vecs[10] = '{ch: 0, p: 8,   h: 4,   ok: 1'b1};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_running", running, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- default divide-by-two on ch0 ----------------
        en[0] = 1'b1;
        @(negedge clk);
        check("start_lat_clk_out", clk_out[0], 0);
        check("start_lat_running", running[0], 0);
        @(negedge clk);
        check("start_clk_out", clk_out[0], 1);
        check("start_tick", tick[0], 1);
        expect_periods(0, 2, 1, 4);
        en[0] = 1'b0;
        wait_idle(0, 8);

        // ---------------- configuration table ----------------
        for (int i = 0; i < 11; i++) begin
            cfg_write(vecs[i].ch, vecs[i].p, vecs[i].h, vecs[i].ok);
        end

        // ---------------- ch1 at P=5,H=2 survives illegal writes ----------------
        en[1] = 1'b1;
        wait_tick(1, 10);
        expect_periods(1, 5, 2, 4);
        en[1] = 1'b0;
        wait_idle(1, 12);

        // ---------------- ch0 reconfigured mid-period ----------------
        en[0] = 1'b1;
        wait_tick(0, 10);
        check("recfg_j0_clk_out", clk_out[0], 1);
        cfg_we     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 8'd4;
        cfg_high   = 8'd1;
        exp_q.push_back(1'b1);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            if (j == 1) cfg_we = 1'b0;
            if (j == 2) begin
                e = exp_q.pop_front();
                check("recfg_ack", cfg_ack, e);
                check("recfg_err", cfg_err, !e);
            end
            check("recfg_old_clk_out", clk_out[0], j < 4);
            check("recfg_old_tick", tick[0], 0);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("recfg_new_clk_out", clk_out[0], (k % 4) < 1);
            check("recfg_new_tick", tick[0], (k % 4) == 0);
        end
        en[0] = 1'b0;
        wait_idle(0, 12);

        // ---------------- ch2 drain without truncation ----------------
        en[2] = 1'b1;
        wait_tick(2, 10);
        en[2] = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check("drain_clk_out", clk_out[2], j < 3);
            check("drain_tick", tick[2], 0);
            check("drain_running", running[2], j < 6);
        end
        @(negedge clk);
        check("drain_stays_idle", running[2], 0);

        // ---------------- re-request during drain ----------------
        en[2] = 1'b1;
        wait_tick(2, 10);
        en[2] = 1'b0;
        for (int j = 1; j < 18; j++) begin
            @(negedge clk);
            if (j == 2) en[2] = 1'b1;
            check("redrain_clk_out", clk_out[2], (j % 6) < 3);
            check("redrain_tick", tick[2], (j % 6) == 0);
            check("redrain_running", running[2], 1);
        end

        // ---------------- asynchronous reset mid-high ----------------
        wait_tick(2, 10);
        @(negedge clk);
        @(negedge clk);
        check("prerst_clk_out", clk_out[2], 1);
        rst_n = 1'b0;
        en    = '0;
        #1;
        check("async_rst_clk_out", clk_out[2], 0);
        check("async_rst_running", running[2], 0);
        check("async_rst_tick", tick[2], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_running", running, 0);
        en[2] = 1'b1;
        @(negedge clk);
        check("postrst_lat_clk_out", clk_out[2], 0);
        @(negedge clk);
        check("postrst_tick", tick[2], 1);
        expect_periods(2, 2, 1, 3);
        en[2] = 1'b0;
        wait_idle(2, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_clk_div_bank
`default_nettype wire
